// File: rtl/bcd_seg7_scanner.sv
// rtl/bcd_seg7_scanner.sv - multiplexed BCD to 7-segment scanner with anti-ghosting gap
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_seg7_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

   localparam logic [0:0] S_GAP   = 1'b0;
   localparam logic [0:0] S_DRIVE = 1'b1;

   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [IDX_W-1:0]        r_idx;
   logic [DIV_W-1:0]        r_div_cnt;
   logic [0:0]              r_state;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_an;
   logic                    r_frame_done;

   logic [3:0]              w_digit;
   logic [6:0]              w_seg_next;
`ifdef LEADING_ZERO_BLANK_EN
   logic                    w_upper_nz;
`endif

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h40;
      endcase
   endfunction

   always_comb begin
      w_digit    = r_shadow[{r_idx, 2'b00} +: 4];
      w_seg_next = decode(w_digit);
`ifdef LEADING_ZERO_BLANK_EN
      // A digit is blank only if it and every more-significant digit are zero.
      w_upper_nz = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (IDX_W'(j) >= r_idx && r_shadow[4*j +: 4] != 4'd0) begin
            w_upper_nz = 1'b1;
         end
      end
      if (r_idx != '0 && !w_upper_nz) begin
         w_seg_next = 7'h00;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shadow     <= '0;
         r_idx        <= '0;
         r_div_cnt    <= '0;
         r_state      <= S_GAP;
         r_seg        <= '0;
         r_an         <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (load) begin
            r_shadow <= bcd_in;
         end
         r_frame_done <= 1'b0;
         case (r_state)
            S_GAP: begin
               r_state   <= S_DRIVE;
               r_an      <= NUM_DIGITS'(1) << r_idx;
               r_seg     <= w_seg_next;
               r_div_cnt <= DIV_W'(1);
            end
            default: begin
               if (r_div_cnt == DIV_LAST) begin
                  // Blank everything for one cycle before moving to the next digit.
                  r_state   <= S_GAP;
                  r_div_cnt <= '0;
                  r_an      <= '0;
                  r_seg     <= '0;
                  if (r_idx == IDX_LAST) begin
                     r_idx        <= '0;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else begin
                  r_div_cnt <= r_div_cnt + 1'b1;
                  r_seg     <= w_seg_next;
               end
            end
         endcase
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_seg7_scanner.sv
// tb/tb_bcd_seg7_scanner.sv - randomized self-checking bench for bcd_seg7_scanner
module tb_bcd_seg7_scanner;

   localparam int ND = 4;
   localparam int RD = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            load = 1'b0;
   logic [4*ND-1:0] bcd_in = '0;
   logic [6:0]      seg;
   logic [ND-1:0]   an;
   logic            frame_done;

   int              checks = 0;
   int              failures = 0;
   int              k = 0;
   logic [4*ND-1:0] m_shadow = '0;

   always #5 clk = ~clk;

   bcd_seg7_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .bcd_in     (bcd_in),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [4*ND-1:0] sh, input int d);
      logic [3:0] v;
      v = sh[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      if (d > 0 && (sh >> (4*d)) == 0) return 7'h00;
`endif
      case (v)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   // k counts edges since reset release; slot/phase follow from plain division.
   task automatic step();
      int            d;
      int            ph;
      logic [ND-1:0] e_an;
      logic [6:0]    e_seg;
      logic          e_fd;
      @(posedge clk);
      d  = (k / RD) % ND;
      ph = k % RD;
      if (ph < RD - 1) begin
         e_an  = ND'(1) << d;
         e_seg = ref_seg(m_shadow, d);
      end else begin
         e_an  = '0;
         e_seg = '0;
      end
      e_fd = (ph == RD - 1) && (d == ND - 1);
      if (load) m_shadow = bcd_in;
      k++;
      #1;
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("frame_done", 32'(frame_done), 32'(e_fd));
   endtask

   task automatic load_and_scan(input logic [4*ND-1:0] v);
      load   = 1'b1;
      bcd_in = v;
      step();
      load = 1'b0;
      repeat (ND*RD + 3) step();
   endtask

   initial begin
      logic [4*ND-1:0] pats [4];
      pats[0] = 16'h00A9;
      pats[1] = 16'h0050;
      pats[2] = 16'h0000;
      pats[3] = 16'h0007;

      repeat (3) @(posedge clk);
      #1;
      check("rst_seg", 32'(seg), 32'h0);
      check("rst_an", 32'(an), 32'h0);
      check("rst_fd", 32'(frame_done), 32'h0);
      reset = 1'b1;

      load   = 1'b1;
      bcd_in = 16'h4321;
      step();
      load = 1'b0;
      repeat (2*ND*RD) step();

      // Asynchronous reset in the middle of a DRIVE slot.
      reset = 1'b0;
      #1;
      check("async_seg", 32'(seg), 32'h0);
      check("async_an", 32'(an), 32'h0);
      check("async_fd", 32'(frame_done), 32'h0);
      @(posedge clk);
      #1;
      check("hold_an", 32'(an), 32'h0);
      reset    = 1'b1;
      k        = 0;
      m_shadow = '0;

      foreach (pats[i]) load_and_scan(pats[i]);

      repeat (600) begin
         load = ($urandom_range(0, 5) == 0);
         for (int j = 0; j < ND; j++) begin
            bcd_in[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_seg7_scanner.md
# bcd_seg7_scanner

Downstream consumer of the mod-10 digit counters. Latches a packed vector of BCD digits, one per cascaded counter, on a load strobe. Time-multiplexes those digits onto a common-segment 7-segment display using an internal refresh prescaler and a one-cycle anti-ghosting gap between digits. All display outputs are registered.

## Interface
- NUM_DIGITS, 4, number of digits scanned (2..8)
- REFRESH_DIV, 1000, clk cycles per digit slot including the gap cycle (>= 2)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- load  input  1  when high at a clk edge, shadow register <= bcd_in
- bcd_in  input  4*NUM_DIGITS  packed digits; digit i in [4i+3:4i], digit 0 = least significant
- seg  output  7  segment drive, active-high, bit0=a … bit6=g
- an  output  NUM_DIGITS  one-hot digit enable, active-high; bit i selects digit i
- frame_done  output  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Reset (reset=0, async): shadow=0, idx=0, div_cnt=0, state=GAP, seg=0, an=0, frame_done=0.
- FSM has two states:
  - GAP: lasts exactly 1 cycle; div_cnt=0. On the next edge: state<=DRIVE, an<=onehot(idx), seg<=decode(shadow[idx]), div_cnt<=1.
  - DRIVE: div_cnt increments each edge. While div_cnt<REFRESH_DIV-1: an holds and seg<=decode(shadow[idx]) every edge. At div_cnt==REFRESH_DIV-1: state<=GAP, div_cnt<=0, an<=0, seg<=0, idx<=idx+1, wrapping NUM_DIGITS-1→0.
- frame_done<=1 on the edge where idx wraps NUM_DIGITS-1→0, else 0.
- Decode: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Values 10–15 (invalid BCD) = 0x40 (dash).
- load during DRIVE takes effect on seg at the following edge. load during GAP takes effect at the GAP→DRIVE edge. load is sampled every cycle regardless of state. There is no handshake and no backpressure.
- Reset asserted mid-scan: all state returns to reset values immediately and asynchronously. The scan restarts at digit 0 through a GAP cycle.

## Timing
- Digit slot = REFRESH_DIV cycles: 1 GAP + REFRESH_DIV-1 DRIVE. Frame = NUM_DIGITS*REFRESH_DIV cycles.
- First edge after reset release: an=onehot(0), seg=decode(shadow[0]).
- load at edge N with state DRIVE → seg reflects the new digit after edge N+1. Latency is 2 edges from bcd_in valid to seg.
- an is never non-zero in two consecutive slots without an intervening all-zero cycle.
- seg=0 whenever an=0.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit i>0 outputs seg=0 (an still driven normally) when shadow digits i..NUM_DIGITS-1 are all 0.
  - Digit 0 is never blanked.
  - Invalid digits count as non-zero.
- Not defined: every digit is decoded normally and leading zeros show 0x3F.

## Test plan
- Reset values: reset=0 mid-DRIVE → seg=0, an=0, frame_done=0 immediately, without waiting for a clk edge. After release, first edge gives an=0001, seg=0x3F.
- Scan order, with REFRESH_DIV=4, NUM_DIGITS=4, load bcd_in=0x4321:
  - an follows 0001,0001,0001,0000,0010,…,1000,0000,0001.
  - seg is 0x06, 0x5B, 0x4F, 0x66 in turn.
  - frame_done pulses once per 16 cycles, coincident with the 1000→0000 gap edge.
- Invalid BCD: bcd_in=0x00A9 → digit0 seg=0x6F, digit1 seg=0x40.
- Mid-slot load: while digit 0 is driven, load 0x0007 → seg becomes 0x07 on the second edge after load. an is unchanged and the slot length is unchanged.
- Blanking, with bcd_in=0x0050:
  - LEADING_ZERO_BLANK_EN defined → digit3 and digit2 seg=0, digit1=0x6D, digit0=0x3F.
  - Not defined → digit3=0x3F, digit2=0x3F, digit1=0x6D, digit0=0x3F.
- Wrap/all-zero: bcd_in=0x0000 with blanking enabled → only digit 0 shows 0x3F. Digits 1–3 show seg=0 while their an bits are still asserted in turn.
